// File: rtl/shift_sequencer_if.sv
// Request/result bundle for shift_sequencer.
// master: the requester driving start/op/Rin/n; slave: the sequencer.
interface shift_sequencer_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] Rin;
   logic [4:0]  n;
   logic [31:0] Rx;
   logic        busy;
   logic        done;

   modport master (
      output start, op, Rin, n,
      input  Rx, busy, done
   );

   modport slave (
      input  start, op, Rin, n,
      output Rx, busy, done
   );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: shifts/rotates a 32-bit value by 0..31 positions.
// Default build shifts one bit per cycle (latency n+1).
// Define SHIFT_BARREL_EN to compute the whole result in one step at start
// (latency 1 for every n, SHIFT never entered).
//
// state | meaning
// IDLE  | waiting for start; op/Rin/n captured on start
// SHIFT | one-bit shift of the work register per cycle, counter counts down
// DONE  | Rx holds the fresh result, done pulses for this single cycle
module shift_sequencer (
   input  logic              clk,
   input  logic              rst,
   shift_sequencer_if.slave  bus
);

   localparam logic [1:0] OP_LSL = 2'b00;
   localparam logic [1:0] OP_LSR = 2'b01;
   localparam logic [1:0] OP_ASR = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] work_q, work_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] rx_q;
   logic [31:0] rx_val;
   logic        rx_load;

   function automatic logic [31:0] shift_one(input logic [1:0] kind, input logic [31:0] w);
      case (kind)
         OP_LSL:  return {w[30:0], 1'b0};
         OP_LSR:  return {1'b0, w[31:1]};
         OP_ASR:  return {w[31], w[31:1]};
         default: return {w[0], w[31:1]};
      endcase
   endfunction

`ifdef SHIFT_BARREL_EN
   function automatic logic [31:0] shift_n(input logic [1:0] kind, input logic [31:0] w,
                                           input logic [4:0] amt);
      logic [63:0] rot;
      rot = {w, w} >> amt;
      case (kind)
         OP_LSL:  return w << amt;
         OP_LSR:  return w >> amt;
         OP_ASR:  return $signed(w) >>> amt;
         default: return rot[31:0];
      endcase
   endfunction
`endif

   // Next-state, datapath updates and result-load decision.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rx_load = 1'b0;
      rx_val  = work_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d = bus.op;
`ifdef SHIFT_BARREL_EN
               work_d  = shift_n(bus.op, bus.Rin, bus.n);
               cnt_d   = '0;
               state_d = DONE;
               rx_load = 1'b1;
               rx_val  = work_d;
`else
               work_d = bus.Rin;
               cnt_d  = bus.n;
               if (bus.n == 5'd0) begin
                  state_d = DONE;
                  rx_load = 1'b1;
                  rx_val  = bus.Rin;
               end else begin
                  state_d = SHIFT;
               end
`endif
            end
         end
         SHIFT: begin
            work_d = shift_one(op_q, work_q);
            cnt_d  = cnt_q - 5'd1;
            // Final shift happens in the cycle that sees count 1.
            if (cnt_q == 5'd1) begin
               state_d = DONE;
               rx_load = 1'b1;
               rx_val  = work_d;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, work register, counter and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         rx_q    <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         if (rx_load) begin
            rx_q <= rx_val;
         end
      end
   end

   assign bus.Rx   = rx_q;
   assign bus.busy = (state_q != IDLE);
   assign bus.done = (state_q == DONE);

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-002 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin a shift, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2 bits, shift kind: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-006 The block SHALL have port Rin, input, 32 bits, source register value.
REQ-007 The block SHALL have port n, input, 5 bits, shift amount 0..31.
REQ-008 The block SHALL have port Rx, output, 32 bits, result register.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit, one-cycle pulse marking a valid new Rx.

Function
REQ-011 The block SHALL implement a 3-state FSM with states IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at edge T, the block SHALL latch op and Rin into an internal 32-bit work register and n into a 5-bit down-counter.
REQ-013 From IDLE with start=1 and n=0, the FSM SHALL go to DONE, and the work register SHALL equal Rin unchanged.
REQ-014 From IDLE with start=1 and n>0, the FSM SHALL go to SHIFT.
REQ-015 Each SHIFT cycle SHALL shift the work register by exactly 1 bit and decrement the counter.
REQ-016 LSL SHALL shift left with 0 fill; LSR SHALL shift right with 0 fill; ASR SHALL shift right replicating bit 31; ROR SHALL rotate right with bit 0 moving to bit 31.
REQ-017 When the counter equals 1 in SHIFT, the FSM SHALL go to DONE after that final shift, so SHIFT lasts exactly n cycles.
REQ-018 On entry to DONE, Rx SHALL load the work register.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-020 Latency SHALL be n+1 cycles from the start-sampling edge to the done-high cycle.
REQ-021 Rx SHALL hold its value until the next DONE entry.
REQ-022 start SHALL be ignored while busy=1, including in the DONE cycle; a new request is accepted at the first IDLE cycle.
REQ-023 Changes to op, Rin or n after the start-sampling edge SHALL NOT affect the operation in flight.
REQ-024 done SHALL be low in IDLE and in SHIFT.

Reset
REQ-025 rst=1 at any clock edge SHALL force the FSM to IDLE, Rx=0, busy=0, done=0, and clear the counter and work register.
REQ-026 rst SHALL take priority over start.
REQ-027 A reset during SHIFT SHALL abort the operation with no done pulse and leave Rx at 0.

Configuration
REQ-028 The macro SHIFT_BARREL_EN SHALL select the implementation.
REQ-029 With SHIFT_BARREL_EN defined, the block SHALL compute the full n-bit result combinationally at start and go IDLE -> DONE for every n, giving a fixed latency of 1 cycle; SHIFT SHALL be unreachable.
REQ-030 With SHIFT_BARREL_EN undefined, the block SHALL behave as REQ-012 to REQ-020 (1 bit per cycle).
REQ-031 The port list, results and reset behaviour SHALL be identical in both builds.

Verification
REQ-032 LSL, Rin=0x00000001, n=4, start at edge T -> busy high for T+1..T+5, done high in cycle T+5, Rx=0x00000010.
REQ-033 ASR, Rin=0x80000000, n=31 -> done high 32 cycles after start, Rx=0xFFFFFFFF; the same inputs with LSR -> Rx=0x00000001.
REQ-034 ROR, Rin=0x00000001, n=1 -> Rx=0x80000000 with done in cycle T+2; n=0, Rin=0xDEADBEEF -> Rx=0xDEADBEEF with done in cycle T+1.
REQ-035 Start LSL n=8, then pulse start with different Rin and n during SHIFT and DONE -> the second request is ignored, exactly one done pulse occurs, and the result reflects the first request only.
REQ-036 Start LSL n=10, assert rst in the 4th SHIFT cycle -> next cycle IDLE, Rx=0, no done pulse; a fresh start afterwards completes correctly.
REQ-037 Rebuild with SHIFT_BARREL_EN and rerun REQ-032 to REQ-034 -> identical Rx values, with done always in cycle T+1.
